// File: rtl/ext_fifo_pkg.sv
// Shared constants and types for the extraction-port drain FIFO.
package ext_fifo_pkg;

  localparam int          EXT_DATA_WIDTH   = 32;
  localparam int          BYTES_PER_WORD   = EXT_DATA_WIDTH / 8;
  localparam logic [31:0] EXT_FIFO_ADDRESS = 32'h0001_0150;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/ext_fifo_mem.sv
// Word storage for the drain FIFO: RAM, wrap-bit pointers, status decode and drop logic.
// Optional drop counter enabled by EXT_FIFO_DROP_CNT_EN.
module ext_fifo_mem
  import ext_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = EXT_DATA_WIDTH,
  parameter int DEPTH_LOG  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_enb_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG:0]    level_o,
`ifdef EXT_FIFO_DROP_CNT_EN
  output logic [15:0]           drop_count_o,
`endif
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG];
  logic [DEPTH_LOG:0]    wptr_q, wptr_d;
  logic [DEPTH_LOG:0]    rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_ok, wr_drop;

  assign full_o  = (wptr_q[DEPTH_LOG] != rptr_q[DEPTH_LOG]) &&
                   (wptr_q[DEPTH_LOG-1:0] == rptr_q[DEPTH_LOG-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;

  // Full is the registered value, so a pop on the same edge never rescues a write.
  assign wr_ok   = wr_enb_i && !full_o;
  assign wr_drop = wr_enb_i && full_o;

  assign rd_data_o = mem_q[rptr_q[DEPTH_LOG-1:0]];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (wr_ok)   wptr_d = wptr_q + 1'b1;
    if (rd_en_i) rptr_d = rptr_q + 1'b1;
    if (wr_drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q[DEPTH_LOG-1:0]] <= wr_data_i;
  end

  assign overflow_o = overflow_q;

`ifdef EXT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (wr_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: rtl/ext_fifo_drain.sv
// Drains processor extraction-port words into a little-endian valid/ready byte stream.
// Optional DROP_COUNT output enabled by EXT_FIFO_DROP_CNT_EN.
module ext_fifo_drain
  import ext_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = EXT_DATA_WIDTH,
  parameter int DEPTH_LOG  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_enb_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [7:0]            byte_out_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG:0]    level_o,
`ifdef EXT_FIFO_DROP_CNT_EN
  output logic [15:0]           drop_count_o,
`endif
  output logic                  overflow_o
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  ser_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_word;

  ext_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG  (DEPTH_LOG)
  ) u_mem (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_enb_i     (wr_enb_i),
    .wr_data_i    (wr_data_i),
    .rd_en_i      (pop),
    .rd_data_o    (head_word),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .level_o      (level_o),
`ifdef EXT_FIFO_DROP_CNT_EN
    .drop_count_o (drop_count_o),
`endif
    .overflow_o   (overflow_o)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!empty_o) begin
          shift_d = head_word;
          idx_d   = '0;
          pop     = 1'b1;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        valid_d = 1'b1;
        if (byte_ready_i) begin
          if (idx_q != LAST_IDX) begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + 1'b1;
          end else if (!empty_o) begin
            // Back-to-back reload keeps the stream bubble-free across words.
            shift_d = head_word;
            idx_d   = '0;
            pop     = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign byte_out_o   = shift_q[7:0];
  assign byte_valid_o = valid_q;

endmodule

// File: tb/tb_ext_fifo_drain.sv
// Self-checking bench for ext_fifo_drain against a queue-based behavioural model.
module tb_ext_fifo_drain;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [31:0] data = '0;
  logic        ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        full, empty, overflow;
  logic [4:0]  level;
`ifdef EXT_FIFO_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_store[$];
  logic [7:0]  m_bytes[$];
  logic        m_ovf = 1'b0;
  int          m_drops = 0;

  always #5 clk = ~clk;

  ext_fifo_drain dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_enb_i     (wr),
    .wr_data_i    (data),
    .byte_out_o   (byte_out),
    .byte_valid_o (byte_valid),
    .byte_ready_i (ready),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
`ifdef EXT_FIFO_DROP_CNT_EN
    .drop_count_o (drop_count),
`endif
    .overflow_o   (overflow)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input bool_chk_byte_zero);
    cmp("valid", 32'(byte_valid), 32'(m_bytes.size() > 0));
    if (m_bytes.size() > 0) cmp("byte", 32'(byte_out), 32'(m_bytes[0]));
    else if (bool_chk_byte_zero) cmp("byte_rst", 32'(byte_out), 32'h0);
    cmp("level", 32'(level), 32'(m_store.size()));
    cmp("full", 32'(full), 32'(m_store.size() == DEPTH));
    cmp("empty", 32'(empty), 32'(m_store.size() == 0));
    cmp("overflow", 32'(overflow), 32'(m_ovf));
`ifdef EXT_FIFO_DROP_CNT_EN
    cmp("drop_count", 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // Advance the model by one edge using the inputs currently applied, then the DUT.
  task automatic step();
    logic [31:0] w;
    bit full_pre;
    full_pre = (m_store.size() == DEPTH);
    if (rst) begin
      m_store.delete();
      m_bytes.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      if (m_bytes.size() > 0 && ready) void'(m_bytes.pop_front());
      if (m_bytes.size() == 0 && m_store.size() > 0) begin
        w = m_store.pop_front();
        for (int b = 0; b < 4; b++) m_bytes.push_back(w[8*b +: 8]);
      end
      if (wr) begin
        if (full_pre) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_store.push_back(data);
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(rst);
  endtask

  task automatic drive(input logic w_en, input logic [31:0] d, input logic rdy);
    wr    = w_en;
    data  = d;
    ready = rdy;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int written;
    #1;
    // reset state
    do_reset();
    do_reset();

    // single word, continuous ready
    drive(1'b1, 32'hDDCC_BBAA, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b1);

    // fill with sink stalled, one write dropped, then drain
    for (int i = 1; i <= 18; i++) drive(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 72; i++) drive(1'b0, 32'h0, 1'b1);

    // backpressure within one word
    drive(1'b1, 32'h4433_2211, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    begin
      logic [6:0] pat;
      pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
      for (int i = 0; i < 7; i++) drive(1'b0, 32'h0, pat[i]);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1);

    // reset mid-word with words queued
    drive(1'b1, 32'h4433_2211, 1'b0);
    drive(1'b1, 32'hA5A5_0001, 1'b0);
    drive(1'b1, 32'hA5A5_0002, 1'b0);
    drive(1'b1, 32'hA5A5_0003, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 1'b1);

    // randomized traffic through the pointer wrap, never overfilling
    written = 0;
    while (written < 40) begin
      logic w_en;
      w_en = ($urandom_range(0, 99) < 60) && (m_store.size() < DEPTH);
      if (w_en) written++;
      drive(w_en, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 200; i++) drive(1'b0, 32'h0, 1'($urandom_range(0, 1)));
    cmp("rand_ovf", 32'(overflow), 32'h0);

    // full storage plus a word-completing pop and a write on the same edge
    do_reset();
    for (int i = 0; i < 17; i++) drive(1'b1, 32'hC000_0000 | 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);
    cmp("sim_pop_level", 32'(level), 32'd15);
    cmp("sim_pop_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 80; i++) drive(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_fifo_drain.md
Name: ext_fifo_drain

Overview:
- Downstream consumer of the processor's extraction port (EXT_FIFO_WR_ENB / EXT_FIFO_WR_DATA, one-cycle pulse per store to 32'h00010150).
- Buffers 32-bit words in a synchronous FIFO and serialises them, little-endian, onto an 8-bit valid/ready byte stream.
- The byte stream feeds the debug UART / host link.
- Never stalls the processor: writes arriving while full are dropped and flagged.

Parameters:
- DATA_WIDTH, 32, width of extracted words. Fixed; must be a multiple of 8.
- DEPTH_LOG, 4, FIFO depth is 2^DEPTH_LOG words.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- WR_ENB  in  1  write strobe from processor extraction port.
- WR_DATA  in  DATA_WIDTH  word to buffer.
- BYTE_OUT  out  8  current byte.
- BYTE_VALID  out  1  BYTE_OUT holds a valid byte.
- BYTE_READY  in  1  sink accepts the byte.
- FULL  out  1  FIFO storage holds 2^DEPTH_LOG words.
- EMPTY  out  1  FIFO storage holds 0 words.
- LEVEL  out  DEPTH_LOG+1  words in storage; excludes the word in the serialiser.
- OVERFLOW  out  1  sticky; a write was dropped.

Behaviour:
- Reset: single clock, one synchronous active-high reset (RST). On reset:
  - Pointers, LEVEL, BYTE_OUT, BYTE_VALID, OVERFLOW = 0; EMPTY = 1; FULL = 0; state = IDLE.
  - Reset mid-word discards the partial word and all stored words.
- Storage:
  - Read/write pointers are DEPTH_LOG+1 bits with wrap bit.
  - FULL when the pointers differ only in the MSB; EMPTY when they are equal.
  - Pointers increment modulo 2^(DEPTH_LOG+1).
- Write:
  - On an edge with WR_ENB=1 and FULL=0 (registered value before the edge), store WR_DATA and advance the write pointer.
  - WR_ENB=1 with FULL=1: data dropped, OVERFLOW set to 1. OVERFLOW clears only on RST.
  - A write that arrives while full is dropped even if a pop occurs on the same edge.
- Serialiser FSM, state IDLE:
  - BYTE_VALID=0.
  - If EMPTY=0: load the head word into the shift register, advance the read pointer, set idx=0, go to SEND.
- Serialiser FSM, state SEND:
  - BYTE_VALID=1, BYTE_OUT=shift[7:0].
  - On BYTE_READY=1 with idx<3: shift right by 8, idx++.
  - On BYTE_READY=1 with idx==3:
    - if EMPTY=0, load the next word directly (stay in SEND, idx=0, no bubble);
    - else go to IDLE.
  - BYTE_READY=0: BYTE_OUT and BYTE_VALID held stable.
- Latency: a word written on edge e shows BYTE_VALID=1 with byte 0 after edge e+1.
- Throughput: one byte per cycle with BYTE_READY held high, including across word boundaries.
- Simultaneous write and pop: both take effect; LEVEL unchanged.
- Capacity seen by the producer is 2^DEPTH_LOG+1 words: storage plus the serialiser.
- All outputs are registered except FULL, EMPTY and LEVEL, which are decoded from registered pointers.

Optional Feature:
- Macro: EXT_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output DROP_COUNT [15:0], which counts dropped writes, saturates at 16'hFFFF, and resets to 0.
  - OVERFLOW behaviour is unchanged.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package ext_fifo_pkg holds:
  - BYTES_PER_WORD = DATA_WIDTH/8;
  - the serialiser state enum {IDLE, SEND};
  - EXT_FIFO_ADDRESS = 32'h00010150, shared with the processor top.
- Sub-module ext_fifo_mem: storage RAM, pointers, FULL/EMPTY/LEVEL, and the write/drop logic.
- The serialiser FSM lives in ext_fifo_drain.

Test Plan:
- Single write of 32'hDDCCBBAA, BYTE_READY=1 -> BYTE_VALID rises 2 cycles after the WR_ENB cycle; bytes AA, BB, CC, DD on 4 consecutive cycles; then BYTE_VALID=0 and EMPTY=1.
- BYTE_READY=0, 18 consecutive writes of 1..18 -> 17 accepted; FULL=1 and LEVEL=16 after write 17; write 18 dropped; OVERFLOW=1 (DROP_COUNT=1 if enabled). Drain with BYTE_READY=1 -> words 1..17 in order, 68 bytes with no bubbles.
- Backpressure on word 32'h44332211: BYTE_READY pattern 1,0,0,1,0,1,1 -> BYTE_OUT 11 (held), 22 (held two cycles), 33 (held), 44. No byte lost or duplicated.
- Reset mid-word: after byte 22 of 32'h44332211, RST=1 for 1 cycle with 3 words queued -> next cycle BYTE_VALID=0, EMPTY=1, LEVEL=0, OVERFLOW=0. No stale bytes after reset.
- Wrap-around: 40 words through the FIFO with random WR_ENB and BYTE_READY, never exceeding capacity -> output byte stream equals the input words in little-endian byte order; OVERFLOW stays 0.
- Full plus simultaneous pop: LEVEL=16, serialiser finishing idx 3, WR_ENB=1 on the same edge -> write dropped, OVERFLOW=1, LEVEL=15.
